// File: rtl/btn_conditioner_pkg.sv
// Shared defaults, stopwatch channel indices and per-channel event bundle for btn_conditioner.
// Pure declarations: no logic, no latency, no flow control.
package btn_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 120000;
    localparam int LONG_TICKS_DEF      = 20;

    localparam int BTN_RESET = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_START = 3;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic lng;
    } btn_evt_t;

    function automatic int dbc_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, debounce, press/release pulses, optional hold timer (BTN_COND_LONGPRESS_EN).
// Level/pulses change DEBOUNCE_CYCLES+1 edges after the sampling edge; no backpressure, pulses are fire-and-forget.
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_TICKS      = LONG_TICKS_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     raw_i,
    input  logic     tick_i,
    output btn_evt_t evt_o
);

    localparam int             CW      = dbc_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_w;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Any sample matching the accepted level restarts the qualification window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            level_d = s2_q;
            cnt_d   = '0;
            press_d = s2_q;
            rel_d   = !s2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

`ifdef BTN_COND_LONGPRESS_EN
    localparam int             HW       = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Gated by the registered level, so a tick on the press edge itself is not counted.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q) begin
            hold_d = '0;
        end else if (tick_i && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_d == HOLD_MAX);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_w = long_q;
`else
    logic unused_long;
    assign unused_long = tick_i & (LONG_TICKS > 0);
    assign long_w      = 1'b0;
`endif

    assign evt_o = '{level: level_q, press: press_q, rel: rel_q, lng: long_w};

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTN raw button pins into debounced levels plus press/release/long pulses (BTN_COND_LONGPRESS_EN).
// Latency DEBOUNCE_CYCLES+1 edges from the sampling edge; no backpressure, channels fully independent.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_TICKS      = LONG_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               tick,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    btn_evt_t evt [NUM_BTN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_TICKS      (LONG_TICKS)
        ) u_ch (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .raw_i  (btn_raw[i]),
            .tick_i (tick),
            .evt_o  (evt[i])
        );

        assign btn_level[i]   = evt[i].level;
        assign btn_press[i]   = evt[i].press;
        assign btn_release[i] = evt[i].rel;
        assign btn_long[i]    = evt[i].lng;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bursts against a window-based reference model.
// Model rule: a flip happens when the synchronised input has disagreed with the level for the last DC edges,
// all of which lie after the previous flip (or after reset release).
module tb_btn_conditioner;
    import btn_cond_pkg::*;

    localparam int DC = 4;
    localparam int LT = 3;
`ifdef BTN_COND_LONGPRESS_EN
    localparam int LP_EN = 1;
`else
    localparam int LP_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'h0;
    logic       tick = 1'b0;
    logic [3:0] btn_level, btn_press, btn_release, btn_long;

    btn_conditioner #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (DC),
        .LONG_TICKS      (LT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .tick        (tick),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model state; edge n=1 is the first rising edge after reset release.
    int         n;
    logic [3:0] hist [0:8191];
    logic [3:0] m_lvl, m_press, m_rel, m_long;
    int         m_last [4];
    int         m_hold [4];
    int         cyc;
    int         pcnt [4];
    int         rcnt [4];
    int         lcnt [4];

    task automatic model_reset();
        n = 0;
        m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < 4; i++) begin
            m_last[i] = 0;
            m_hold[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic tk);
        logic [3:0] nl;
        logic       flip;
        logic       s2;
        n++;
        hist[n] = raw;
        m_press = '0; m_rel = '0; m_long = '0;
        nl = m_lvl;
        for (int ch = 0; ch < 4; ch++) begin
            if (LP_EN != 0) begin
                if (!m_lvl[ch]) m_hold[ch] = 0;
                else if (tk && m_hold[ch] < LT) begin
                    m_hold[ch] = m_hold[ch] + 1;
                    m_long[ch] = (m_hold[ch] == LT);
                end
            end
            flip = (n - DC + 1 > m_last[ch]);
            for (int m = n - DC + 1; m <= n; m++) begin
                s2 = (m - 2 >= 1) ? hist[m-2][ch] : 1'b0;
                if (s2 == m_lvl[ch]) flip = 1'b0;
            end
            if (flip) begin
                nl[ch]      = ~m_lvl[ch];
                m_last[ch]  = n;
                m_press[ch] = nl[ch];
                m_rel[ch]   = ~nl[ch];
            end
        end
        m_lvl = nl;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 4; i++) begin
            pcnt[i] = 0; rcnt[i] = 0; lcnt[i] = 0;
        end
    endtask

    task automatic step(input logic [3:0] raw, input logic tk);
        btn_raw = raw;
        tick    = tk;
        model_edge(raw, tk);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk_eq("level", {28'd0, btn_level}, {28'd0, m_lvl});
        chk_eq("press", {28'd0, btn_press}, {28'd0, m_press});
        chk_eq("release", {28'd0, btn_release}, {28'd0, m_rel});
        chk_eq("long", {28'd0, btn_long}, {28'd0, m_long});
        for (int i = 0; i < 4; i++) begin
            pcnt[i] += int'(btn_press[i]);
            rcnt[i] += int'(btn_release[i]);
            lcnt[i] += int'(btn_long[i]);
        end
    endtask

    task automatic hold(input logic [3:0] raw, input int cycles);
        for (int c = 0; c < cycles; c++) step(raw, (cyc % 10) == 9);
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, "_level"}, {28'd0, btn_level}, 32'd0);
        chk_eq({tag, "_press"}, {28'd0, btn_press}, 32'd0);
        chk_eq({tag, "_release"}, {28'd0, btn_release}, 32'd0);
        chk_eq({tag, "_long"}, {28'd0, btn_long}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_zero("in_rst");
        rst_n = 1'b1;
    endtask

    logic [3:0] rv;
    int         seg;

    initial begin
        model_reset();
        clr_cnt();
        cyc = 0;
        btn_raw = 4'hF;
        repeat (3) @(negedge clk);
        chk_zero("por");
        rst_n = 1'b1;

        // Held through reset: edge numbering starts at the first sampling edge (step 1 = edge 0).
        hold(4'hF, 5);
        chk_eq("por_lvl_early", {28'd0, btn_level}, 32'd0);
        step(4'hF, 1'b0);
        chk_eq("por_press", {28'd0, btn_press}, 32'hF);
        chk_eq("por_lvl", {28'd0, btn_level}, 32'hF);
        step(4'hF, 1'b0);
        chk_eq("por_press_1cyc", {28'd0, btn_press}, 32'h0);
        hold(4'h0, 12);

        clr_cnt();
        hold(4'h1 << BTN_LAP, 5);
        chk_eq("lap_lvl_early", {28'd0, btn_level}, 32'h0);
        step(4'h1 << BTN_LAP, 1'b0);
        chk_eq("lap_press", {28'd0, btn_press}, 32'h4);
        step(4'h1 << BTN_LAP, 1'b0);
        chk_eq("lap_press_1cyc", {28'd0, btn_press}, 32'h0);
        hold(4'h1 << BTN_LAP, 8);
        hold(4'h0, 5);
        chk_eq("lap_lvl_held", {28'd0, btn_level}, 32'h4);
        step(4'h0, 1'b0);
        chk_eq("lap_release", {28'd0, btn_release}, 32'h4);
        hold(4'h0, 8);

        clr_cnt();
        hold(4'h1, 3); hold(4'h0, 3); hold(4'h1, 3); hold(4'h0, 3);
        hold(4'h1, 12);
        chk_eq("bounce_press_cnt", pcnt[BTN_RESET], 32'd1);
        chk_eq("bounce_rel_cnt", rcnt[BTN_RESET], 32'd0);
        hold(4'h0, 12);

        clr_cnt();
        hold(4'h2, 3);
        hold(4'h0, 12);
        chk_eq("glitch_press_cnt", pcnt[BTN_STOP], 32'd0);
        chk_eq("glitch_rel_cnt", rcnt[BTN_STOP], 32'd0);

        clr_cnt();
        hold(4'h9, 12);
        chk_eq("simul_p0", pcnt[0], 32'd1);
        chk_eq("simul_p1", pcnt[1], 32'd0);
        chk_eq("simul_p2", pcnt[2], 32'd0);
        chk_eq("simul_p3", pcnt[3], 32'd1);
        hold(4'h0, 12);

        clr_cnt();
        hold(4'h1 << BTN_START, 45);
        chk_eq("long_hold_cnt", lcnt[BTN_START], LP_EN);
        hold(4'h0, 12);
        clr_cnt();
        hold(4'h1 << BTN_START, 18);
        hold(4'h0, 12);
        chk_eq("long_short_cnt", lcnt[BTN_START], 32'd0);

        seg = 0;
        rv  = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                rv  = 4'($urandom);
                seg = int'($urandom_range(1, 30));
            end
            seg--;
            if (i == 700) do_reset();
            step(rv, $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning for the stopwatch's push-buttons. It takes the raw asynchronous button pins and makes them safe to use: each is synchronised into the `clk` domain, then debounced. Per button it emits a clean level plus one-cycle press and release pulses, which the stopwatch control logic consumes instead of raw `ui_in` bits. It sits between the `ui_in[3:0]` pins and the stopwatch's reset/stop/lap/start logic.

## Interface
Parameters:
- `NUM_BTN`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 120000: clock cycles an input must hold a new value before it is accepted (10 ms at 12 MHz). Legal range ≥ 1.
- `LONG_TICKS`, 20: number of `tick` pulses a button must stay held to raise `btn_long`. Legal range ≥ 1. Used only with `BTN_COND_LONGPRESS_EN`.

Ports:
- `clk`, input, 1: sole clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low. Release is synchronous to `clk` upstream.
- `btn_raw`, input, `NUM_BTN`: raw, asynchronous, active-high button pins.
- `tick`, input, 1: one-cycle time-base pulse (the 100 ms stopwatch tick). Used for long-press timing only.
- `btn_level`, output, `NUM_BTN`: debounced, registered button level.
- `btn_press`, output, `NUM_BTN`: one-cycle pulse when `btn_level` goes 0→1.
- `btn_release`, output, `NUM_BTN`: one-cycle pulse when `btn_level` goes 1→0.
- `btn_long`, output, `NUM_BTN`: one-cycle long-press pulse. Tied to 0 when the feature is compiled out.

## Operation
- Every output and internal flop resets to 0: sync stages, debounce counters, `btn_level`, all pulse outputs, hold counters.
- Each channel is fully independent. Several buttons may change, press or release in the same cycle with no interaction and no priority.
- Synchroniser: two flops per channel, `s1 <= btn_raw[i]`, then `s2 <= s1`.
- Debounce, per channel, uses a counter `cnt` of width `max(1,$clog2(DEBOUNCE_CYCLES))`:
  - If `s2 == btn_level[i]`: `cnt <= 0`.
  - If `s2 != btn_level[i]` and `cnt != DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s2 != btn_level[i]` and `cnt == DEBOUNCE_CYCLES-1`: `btn_level[i] <= s2`, `cnt <= 0`. In the same edge, `btn_press[i] <= s2` and `btn_release[i] <= !s2`.
  - A bounce back to the old level at any count clears `cnt`. Any excursion shorter than `DEBOUNCE_CYCLES` cycles after sync is invisible.
- Pulse outputs are registered. They are 0 in every cycle other than the one that follows a level flip.
- The counter never wraps past `DEBOUNCE_CYCLES-1`.
- A button held through reset is seen as a press `DEBOUNCE_CYCLES+1` edges after `rst_n` deasserts.

## Timing
- Assume `btn_raw[i]` settles to a new value before edge k (k is the edge that samples it into `s1`). Then `btn_level[i]` and the matching press/release pulse change at edge k+1+`DEBOUNCE_CYCLES`.
- With `DEBOUNCE_CYCLES`=1, the flip is at edge k+2.
- Pulse width is exactly one `clk` cycle.
- Minimum spacing between two accepted transitions on one channel is `DEBOUNCE_CYCLES` cycles.
- Reset mid-count: counters and level clear immediately and asynchronously. A pulse in flight is dropped.

## Configuration
Macro: `BTN_COND_LONGPRESS_EN`.
- Defined:
  - Each channel has a hold counter of width `$clog2(LONG_TICKS+1)`, cleared while `btn_level[i]`=0.
  - While the button is held, it increments on `tick` and saturates at `LONG_TICKS`.
  - On the edge where it reaches `LONG_TICKS`, `btn_long[i]` pulses for one cycle. It pulses once per hold and never repeats.
  - A release before that clears the counter without a pulse.
  - A `tick` coinciding with the press edge is not counted.
- Not defined: the hold counters are absent, `btn_long` is constant 0, and `tick` is unused.

## Structure
- Package `btn_cond_pkg` holds:
  - the parameter defaults `DEBOUNCE_CYCLES_DEF` and `LONG_TICKS_DEF`;
  - the channel index constants `BTN_RESET`=0, `BTN_STOP`=1, `BTN_LAP`=2 and `BTN_START`=3, which the stopwatch top uses to pick channels.
- Sub-module `btn_debounce_ch` implements one channel: sync, debounce, pulses and the optional hold counter. The top instantiates it `NUM_BTN` times in a generate loop.

## Test plan
1. Reset: `rst_n`=0 with `btn_raw`=4'hF, release → all outputs 0 during reset. With `DEBOUNCE_CYCLES`=4, `btn_level`=4'hF and `btn_press`=4'hF for one cycle at the 5th edge after release.
2. Clean press with `DEBOUNCE_CYCLES`=4: `btn_raw[2]` 0→1 before edge 0 → `btn_level[2]` rises and `btn_press[2]` pulses exactly at edge 5. Release likewise gives a `btn_release[2]` pulse 5 edges later.
3. Bounce: `btn_raw[0]` toggles 1,0,1,0 at 3-cycle intervals, then holds 1 → no output until 4 cycles of stable `s2`. Exactly one press pulse.
4. Glitch: `btn_raw[1]` high for 3 cycles only → `btn_level[1]` stays 0, no pulses.
5. Simultaneous: `btn_raw` 4'h0→4'h9 in one cycle → `btn_press`=4'h9 in one cycle, others 0.
6. Long press (macro on, `LONG_TICKS`=3, `tick` every 10 cycles): hold `btn_raw[3]` → exactly one `btn_long[3]` pulse on the 3rd tick after press. Releasing after 2 ticks → no pulse. Macro off → `btn_long` always 0.
